// File: rtl/rom_nxm_pkg.sv
// ----------------------------------------------------------------------------
// rom_nxm_pkg
// Shared constants for the rom_nxm_sync read-only memory:
//   - REGMODE selector strings (plain read vs. extra output register)
//   - legal ranges for ADDR_WIDTH and DATA_WIDTH, checked at elaboration
// ----------------------------------------------------------------------------
package rom_nxm_pkg;

    localparam string REGMODE_NOREG  = "NOREG";
    localparam string REGMODE_OUTREG = "OUTREG";

    localparam int ADDR_WIDTH_MIN = 1;
    localparam int ADDR_WIDTH_MAX = 10;
    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 36;

endpackage

// File: rtl/rom_nxm_sync_if.sv
// ----------------------------------------------------------------------------
// rom_nxm_sync_if
// Read bus of the synchronous ROM.
//   CE : clock enable for all ROM state
//   RE : read request, sampled when CE=1
//   AD : read address, sampled with RE
//   DO : read data
//   DV : DO holds data for an accepted read
// master drives the request side, slave (the ROM) drives DO/DV.
// ----------------------------------------------------------------------------
interface rom_nxm_sync_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 1
);

    logic                  CE;
    logic                  RE;
    logic [ADDR_WIDTH-1:0] AD;
    logic [DATA_WIDTH-1:0] DO;
    logic                  DV;

    modport master (output CE, RE, AD, input DO, DV);
    modport slave  (input CE, RE, AD, output DO, DV);

endinterface

// File: rtl/rom_xmux.sv
// ----------------------------------------------------------------------------
// rom_xmux
// Constant-content word selector built as a binary mux tree, LSB level first.
// Each tree node is a 2:1 conditional select, so an unknown address bit
// merges the two sub-trees bit by bit: the result is the common value of all
// words matching the known address bits, or X where those words differ.
// Ports:
//   addr : word index (unsigned)
//   word : selected word
// ----------------------------------------------------------------------------
module rom_xmux #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 1,
    parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INITVAL = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // Level l holds DEPTH>>l nodes; node p of level l covers the words whose
    // upper ADDR_WIDTH-l address bits equal p.
    for (genvar l = 0; l <= ADDR_WIDTH; l++) begin : g_lvl
        localparam int N = DEPTH >> l;
        logic [DATA_WIDTH-1:0] node [N];
        for (genvar p = 0; p < N; p++) begin : g_node
            if (l == 0) begin : g_leaf
                assign node[p] = INITVAL[p*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_mux
                assign node[p] = addr[l-1] ? g_lvl[l-1].node[2*p+1]
                                           : g_lvl[l-1].node[2*p];
            end
        end
    end

    assign word = g_lvl[ADDR_WIDTH].node[0];

endmodule

// File: rtl/rom_nxm_sync.sv
// ----------------------------------------------------------------------------
// rom_nxm_sync
// Synchronous read-only memory, DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH
// bits, contents fixed by INITVAL (word k = INITVAL[k*DATA_WIDTH +: DATA_WIDTH]).
// A read is accepted on a rising CLK edge with CE=1 and RE=1. Read data
// appears 1 cycle later (REGMODE "NOREG") or 2 cycles later ("OUTREG"),
// one read per cycle, in order. CE=0 freezes every register.
// Ports:
//   CLK  : clock, rising edge
//   RSTN : asynchronous active-low reset, clears address/data/valid state
//   bus  : slave side of rom_nxm_sync_if (CE, RE, AD in; DO, DV out)
// ----------------------------------------------------------------------------
module rom_nxm_sync
    import rom_nxm_pkg::*;
#(
    parameter int    ADDR_WIDTH = 6,
    parameter int    DATA_WIDTH = 1,
    parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INITVAL = '0,
    parameter string REGMODE    = "NOREG"
) (
    input logic           CLK,
    input logic           RSTN,
    rom_nxm_sync_if.slave bus
);

    localparam bit IS_OUTREG = (REGMODE == REGMODE_OUTREG);

    if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_addr_width
        $error("rom_nxm_sync: ADDR_WIDTH=%0d outside %0d..%0d",
               ADDR_WIDTH, ADDR_WIDTH_MIN, ADDR_WIDTH_MAX);
    end
    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
        $error("rom_nxm_sync: DATA_WIDTH=%0d outside %0d..%0d",
               DATA_WIDTH, DATA_WIDTH_MIN, DATA_WIDTH_MAX);
    end
    if (!(REGMODE == REGMODE_NOREG || REGMODE == REGMODE_OUTREG)) begin : g_bad_regmode
        $error("rom_nxm_sync: REGMODE must be \"NOREG\" or \"OUTREG\"");
    end

    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  loaded_p1;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] word_p1;
    logic [DATA_WIDTH-1:0] rd_p1;

    assign accept = bus.CE & bus.RE;

    // ---- stage 1: address capture ----
    // Conditional selects instead of if/else so that an unknown CE or RE
    // drives the affected registers unknown rather than silently holding.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            addr_p1   <= '0;
            loaded_p1 <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            addr_p1   <= accept ? bus.AD : addr_p1;
            loaded_p1 <= accept ? 1'b1   : loaded_p1;
            vld_p1    <= bus.CE ? bus.RE : vld_p1;
        end
    end

    rom_xmux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INITVAL    (INITVAL)
    ) u_xmux (
        .addr (addr_p1),
        .word (word_p1)
    );

    // Reset clears the address register to 0, but word 0 need not be zero;
    // the read data stays 0 until the first read has been accepted.
    assign rd_p1 = loaded_p1 ? word_p1 : '0;

    if (IS_OUTREG) begin : g_outreg
        logic [DATA_WIDTH-1:0] dout_p2;
        logic                  vld_p2;

        // ---- stage 2: output register ----
        // Loads only behind a valid stage-1 read so DO keeps its last word
        // while idle.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                dout_p2 <= '0;
                vld_p2  <= 1'b0;
            end else begin
                dout_p2 <= (bus.CE & vld_p1) ? rd_p1 : dout_p2;
                vld_p2  <= bus.CE ? vld_p1 : vld_p2;
            end
        end

        assign bus.DO = dout_p2;
        assign bus.DV = vld_p2;
    end else begin : g_noreg
        assign bus.DO = rd_p1;
        assign bus.DV = vld_p1;
    end

endmodule

// File: doc/rom_nxm_sync.md
ROM_NXM_SYNC -- requirements
Module: rom_nxm_sync

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, address bits; legal 1..10; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, word width; legal 1..36.
REQ-003 SHALL have parameter INITVAL, default all zeros, flat DEPTH*DATA_WIDTH vector; word k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-004 SHALL have parameter REGMODE, default "NOREG", "NOREG" or "OUTREG"; selects the extra output register.
REQ-005 SHALL have port CLK, input, 1, single clock, rising edge.
REQ-006 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port CE, input, 1, clock enable for all state.
REQ-008 SHALL have port RE, input, 1, read request, sampled when CE=1.
REQ-009 SHALL have port AD, input, ADDR_WIDTH, read address, sampled with RE.
REQ-010 SHALL have port DO, output, DATA_WIDTH, read data.
REQ-011 SHALL have port DV, output, 1, DO holds data for an accepted read.

Function
REQ-012 SHALL accept a read at a rising CLK edge when CE=1 and RE=1, capturing AD into the address register.
REQ-013 In NOREG, DO SHALL show the captured address's word from the cycle after acceptance, DV=1 that cycle; latency 1.
REQ-014 In OUTREG, DO SHALL be registered once more; data and DV=1 appear 2 cycles after acceptance.
REQ-015 SHALL sustain one accepted read per cycle with back-to-back RE=1, each read returned in order at fixed latency.
REQ-016 At an edge with CE=1, RE=0, the address register SHALL hold, DV SHALL fall to 0 after the pipeline latency, and DO SHALL hold its last value.
REQ-017 At an edge with CE=0, every register (address, output, DV pipeline) SHALL hold; DO and DV SHALL be unchanged.
REQ-018 Address bits that are X or Z at capture SHALL select, per data bit, the common value of all matching words, or X where those words differ.
REQ-019 CE or RE that is X or Z at an edge SHALL drive DV and the affected registers to X until the next defined-enable edge.
REQ-020 Contents SHALL come only from INITVAL; no write path exists; DO SHALL never depend on AD combinationally.
REQ-021 Word index SHALL equal AD as unsigned; no wrap or out-of-range case exists, since DEPTH covers all codes.

Reset
REQ-022 RSTN=0 SHALL immediately clear the address register, the output register, DO and DV to 0, independent of CLK and CE.
REQ-023 A reset asserted mid-stream SHALL discard all in-flight reads; no DV=1 appears for reads accepted before reset.
REQ-024 After RSTN deasserts, the first edge with CE=1, RE=1 SHALL be treated as a fresh read with full latency.

Structure
REQ-025 REGMODE string constants and the ADDR_WIDTH and DATA_WIDTH legal limits SHALL reside in the shared package rom_nxm_pkg.
REQ-026 The X-aware word-select logic SHALL be the sub-module rom_xmux, parametrised by ADDR_WIDTH and DATA_WIDTH.
REQ-027 Illegal parameter values SHALL raise an elaboration-time error.

Verification
REQ-028 Test 1: ADDR_WIDTH=6, DATA_WIDTH=1, NOREG, INITVAL=64'h8000000000000001; read AD=0, 63, 1 back-to-back -> DO=1, 1, 0 on the three cycles after each read, DV=1 on each.
REQ-029 Test 2: ADDR_WIDTH=4, DATA_WIDTH=8, OUTREG, word k=k*17; RE pulse at AD=5 -> DO=8'h55 with DV=1 exactly 2 cycles later, DV=0 the cycle after.
REQ-030 Test 3: stream of reads with CE=0 for 3 cycles mid-stream -> outputs frozen for 3 cycles, then the sequence resumes in order with no loss or duplication.
REQ-031 Test 4: DATA_WIDTH=1, words 2 and 3 both 1, word 0=0; AD=2'b1x -> DO=1; AD=2'bx0 -> DO=X.
REQ-032 Test 5: OUTREG with a read in flight, RSTN pulsed low between edges -> DO=0 and DV=0 at once, and no DV=1 afterwards until a new read.
REQ-033 Test 6: RE=X with CE=1 at an edge -> DV=X; the next clean RE=0 edge, plus the pipeline latency, returns DV=0.
